// File: rtl/key_matrix_scan_pkg.sv
// Shared definitions for the key matrix scanner and the display driver side.
// KEY_NONE doubles as the blank code on the seven-segment digit inputs.
package key_matrix_scan_pkg;

    localparam logic [4:0]  KEY_NONE = 5'd31;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_SWITCH
    } key_state_t;

    // Lowest set index of a key map, KEY_NONE when the map is empty.
    function automatic logic [4:0] lowest_key(input logic [NUM_KEYS-1:0] map);
        logic [4:0] k;
        k = KEY_NONE;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (map[i] && (k == KEY_NONE)) begin
                k = 5'(i);
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/key_matrix_scan_if.sv
// Matrix pins plus the reported-key outputs of the scanner.
interface key_matrix_scan_if;
    import key_matrix_scan_pkg::*;

    logic [NUM_ROWS-1:0] row_in;
    logic [NUM_COLS-1:0] col_out;
    logic [4:0]          key_code;
    logic                key_valid;
    logic                key_release;
    logic                key_held;

    modport master (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_release,
        input  key_held
    );

    modport slave (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_release,
        output key_held
    );

endinterface

// File: rtl/key_matrix_scan_scan_tick_gen.sv
// Free-running divider: one-clock tick every DIV clocks.
module scan_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 key matrix scanner: column drive, row synchroniser, frame debounce and
// single-key reporting FSM with press/release pulses.
module key_matrix_scan
    import key_matrix_scan_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned SCAN_HZ         = 1000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    key_matrix_scan_if.slave  bus
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned SCW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [NUM_ROWS-1:0] r_row_s1;
    logic [NUM_ROWS-1:0] r_row_s2;
    logic [1:0]          r_col;
    logic [NUM_COLS-1:0] r_col_out;
    logic [NUM_KEYS-1:0] r_frame;
    logic [NUM_KEYS-1:0] r_prev;
    logic [NUM_KEYS-1:0] r_map;
    logic [SCW-1:0]      r_stable;
    logic                r_commit;

    key_state_t          r_state;
    logic [4:0]          r_key_code;
    logic                r_valid;
    logic                r_release;
    logic                r_held;

    logic                w_tick;
    logic [1:0]          w_col_nxt;
    logic [NUM_KEYS-1:0] w_frame_new;
    logic [SCW-1:0]      w_stable_nxt;
    logic [4:0]          w_cand;
    key_state_t          w_state_nxt;
    logic [4:0]          w_code_nxt;
    logic                w_valid_nxt;
    logic                w_release_nxt;
    logic                w_held_nxt;

    scan_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row_s1 <= '1;
            r_row_s2 <= '1;
        end else begin
            r_row_s1 <= bus.row_in;
            r_row_s2 <= r_row_s1;
        end
    end

    // Current column's rows merged in, so frame end can compare the complete frame.
    always_comb begin
        w_col_nxt   = r_col + 2'd1;
        w_frame_new = r_frame;
        w_frame_new[{r_col, 2'b00} +: NUM_ROWS] = ~r_row_s2;
        if (w_frame_new != r_prev) begin
            w_stable_nxt = SCW'(1);
        end else if (r_stable == SCW'(DEBOUNCE_FRAMES)) begin
            w_stable_nxt = r_stable;
        end else begin
            w_stable_nxt = r_stable + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_col_out <= 4'b1110;
            r_frame   <= '0;
            r_prev    <= '0;
            r_map     <= '0;
            r_stable  <= '0;
            r_commit  <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            if (w_tick) begin
                r_frame   <= w_frame_new;
                r_col     <= w_col_nxt;
                r_col_out <= ~(4'b0001 << w_col_nxt);
                if (r_col == 2'd3) begin
                    r_prev   <= w_frame_new;
                    r_stable <= w_stable_nxt;
                    if (w_stable_nxt == SCW'(DEBOUNCE_FRAMES)) begin
                        r_map    <= w_frame_new;
                        r_commit <= 1'b1;
                    end
                end
            end
        end
    end

    assign w_cand = lowest_key(r_map);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_key_code <= KEY_NONE;
            r_valid    <= 1'b0;
            r_release  <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_key_code <= w_code_nxt;
            r_valid    <= w_valid_nxt;
            r_release  <= w_release_nxt;
            r_held     <= w_held_nxt;
        end
    end

    // A key change while held is split into release now, press next cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_key_code;
        w_valid_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_held_nxt    = r_held;
        case (r_state)
            ST_IDLE: begin
                if (r_commit && (w_cand != KEY_NONE)) begin
                    w_code_nxt  = w_cand;
                    w_valid_nxt = 1'b1;
                    w_held_nxt  = 1'b1;
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (r_commit) begin
                    if (w_cand == KEY_NONE) begin
                        w_release_nxt = 1'b1;
                        w_code_nxt    = KEY_NONE;
                        w_held_nxt    = 1'b0;
                        w_state_nxt   = ST_IDLE;
                    end else if (w_cand != r_key_code) begin
                        w_release_nxt = 1'b1;
                        w_state_nxt   = ST_SWITCH;
                    end
                end
            end
            ST_SWITCH: begin
                w_code_nxt  = w_cand;
                w_valid_nxt = 1'b1;
                w_held_nxt  = 1'b1;
                w_state_nxt = ST_HELD;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.col_out     = r_col_out;
    assign bus.key_code    = r_key_code;
    assign bus.key_valid   = r_valid;
    assign bus.key_release = r_release;
    assign bus.key_held    = r_held;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Randomised bench for key_matrix_scan: a virtual keypad drives the rows from the
// column strobe, and a key-level model predicts the reported key and pulse counts.
module tb_key_matrix_scan;
    import key_matrix_scan_pkg::*;

    localparam int FRAME   = 16;
    localparam int DEB     = 2;
    localparam int LAT_MAX = (DEB + 1) * FRAME + 3;
    localparam int SETTLE  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = '0;

    int n_cmp = 0;
    int n_bad = 0;

    int  nv = 0, nr = 0, n_both = 0, n_wide = 0;
    time last_v_t = 0, last_r_t = 0;
    logic pv = 1'b0, pr = 1'b0;

    int m_key = 31;

    always #5 clk = ~clk;

    key_matrix_scan_if bus();

    key_matrix_scan #(
        .CLK_HZ          (16),
        .SCAN_HZ         (4),
        .DEBOUNCE_FRAMES (DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Pressed key at (col,row) shorts that row low while its column is driven.
    always_comb begin
        bus.row_in = '1;
        for (int c = 0; c < 4; c++) begin
            if (!bus.col_out[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[c*4+r]) bus.row_in[r] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.key_valid && bus.key_release) n_both++;
        if ((bus.key_valid && pv) || (bus.key_release && pr)) n_wide++;
        if (bus.key_valid) begin
            nv++;
            last_v_t = $time;
        end
        if (bus.key_release) begin
            nr++;
            last_r_t = $time;
        end
        pv = bus.key_valid;
        pr = bus.key_release;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_key(input logic [15:0] s);
        for (int i = 0; i < 16; i++) begin
            if (s[i]) return i;
        end
        return 31;
    endfunction

    // mode 0: clean change; 1: 3-clock random glitch first; 2: one-frame on/off bounce
    task automatic run_phase(input string tag, input logic [15:0] nk, input int mode);
        int nv0, nr0, b0, w0, exp_key, exp_v, exp_r, dv, dr;
        logic [15:0] old;
        time settle_t;
        old = keys;
        nv0 = nv; nr0 = nr; b0 = n_both; w0 = n_wide;
        if (mode == 1) begin
            repeat (3) begin
                @(negedge clk);
                keys = 16'($urandom);
            end
        end else if (mode == 2) begin
            @(negedge clk);
            keys = nk;
            repeat (FRAME) @(negedge clk);
            keys = old;
            repeat (FRAME - 1) @(negedge clk);
        end
        @(negedge clk);
        keys = nk;
        settle_t = $time;
        repeat (SETTLE) @(negedge clk);

        exp_key = ref_key(nk);
        exp_v   = (exp_key != 31 && exp_key != m_key) ? 1 : 0;
        exp_r   = (m_key != 31 && exp_key != m_key) ? 1 : 0;
        m_key   = exp_key;
        dv = nv - nv0;
        dr = nr - nr0;

        check({tag, ".code"}, int'(bus.key_code), exp_key);
        check({tag, ".held"}, int'(bus.key_held), (exp_key != 31) ? 1 : 0);
        check({tag, ".nvalid"}, dv, exp_v);
        check({tag, ".nrelease"}, dr, exp_r);
        check({tag, ".both"}, n_both - b0, 0);
        check({tag, ".width"}, n_wide - w0, 0);
        if (dv > 0) check({tag, ".lat"}, int'((last_v_t - settle_t) / 10 <= LAT_MAX), 1);
        if (dv > 0 && dr > 0) check({tag, ".swadj"}, int'((last_v_t - last_r_t) / 10), 1);
    endtask

    initial begin
        logic [3:0] exp_col [4];
        logic [3:0] prev_col;
        logic [15:0] s;
        int dt;
        exp_col = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst.col", int'(bus.col_out), 14);
        check("rst.code", int'(bus.key_code), 31);
        check("rst.valid", int'(bus.key_valid), 0);
        check("rst.release", int'(bus.key_release), 0);
        check("rst.held", int'(bus.key_held), 0);
        rst_n = 1'b1;

        prev_col = bus.col_out;
        for (int k = 0; k < 4; k++) begin
            dt = 0;
            while (bus.col_out == prev_col && dt < 8) begin
                @(negedge clk);
                dt++;
            end
            check($sformatf("scan.col%0d", k), int'(bus.col_out), int'(exp_col[k]));
            if (k == 0) check("scan.dt0", int'(dt <= 4), 1);
            else        check($sformatf("scan.dt%0d", k), dt, 4);
            prev_col = bus.col_out;
        end
        check("scan.code", int'(bus.key_code), 31);
        check("scan.held", int'(bus.key_held), 0);

        run_phase("press9", 16'h0200, 0);
        run_phase("rel9", 16'h0000, 0);
        run_phase("bounce9", 16'h0200, 2);
        run_phase("add2", 16'h0204, 0);
        run_phase("drop9", 16'h0004, 0);
        run_phase("relall", 16'h0000, 0);

        for (int p = 0; p < 30; p++) begin
            s = '0;
            repeat ($urandom_range(0, 2)) s[$urandom_range(0, 15)] = 1'b1;
            run_phase($sformatf("rnd%0d", p), s, int'($urandom_range(0, 1)));
        end

        run_phase("hold5", 16'h0020, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.col", int'(bus.col_out), 14);
        check("midrst.code", int'(bus.key_code), 31);
        check("midrst.held", int'(bus.key_held), 0);
        check("midrst.valid", int'(bus.key_valid), 0);
        check("midrst.release", int'(bus.key_release), 0);
        repeat (3) @(negedge clk);
        m_key = 31;
        rst_n = 1'b1;
        run_phase("after_rst5", 16'h0020, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
